// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative M-extension multiply/divide
//
// Purpose: decodes ALUOp/funct3/funct7/op on acceptance and produces a
// registered result. Base RV32I ops finish in one cycle. The M extension
// uses shift-add multiply and restoring divide, one step per cycle.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operation handshake (in_ready is combinational)
//   ALUOp, funct3,       decode fields (sampled only on acceptance)
//   funct7, op
//   src_a, src_b         operands
//   out_valid/out_ready  result handshake
//   result, zero,        registered result, result==0 flag and
//   illegal              unsupported-encoding flag (qualified by out_valid)
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]     opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;      // product sign or quotient sign
  logic                rneg_q, rneg_d;    // remainder sign
  logic [2:0]          f3_q, f3_d;        // selects half / quotient-vs-remainder at the end
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;
  logic                out_valid_q, out_valid_d;

  logic                accept;
  logic                is_m, bad_f7;
  logic [SW-1:0]       shamt;
  logic [XLEN-1:0]     alu_res;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_nxt, mul_prod;
  logic [XLEN:0]       div_sh, div_diff;
  logic [2*XLEN-1:0]   div_nxt;
  logic [XLEN-1:0]     div_quo, div_rem;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
  assign shamt     = src_b[SW-1:0];

  // Field decode and single-cycle datapath
  always_comb begin
    is_m   = (ALUOp == 2'b10) && (op == 7'b0110011) && (funct7 == 7'b0000001);
    bad_f7 = (ALUOp == 2'b10) && op[5] && (funct7 != 7'b0000000) &&
             (funct7 != 7'b0100000) && (funct7 != 7'b0000001);
    alu_res = '0;
    case (ALUOp)
      2'b00: alu_res = src_a + src_b;
      2'b01: alu_res = src_a - src_b;
      2'b11: alu_res = src_b;
      default: begin
        case (funct3)
          3'b000: alu_res = (op[5] & funct7[5]) ? (src_a - src_b) : (src_a + src_b);
          3'b001: alu_res = src_a << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
          3'b100: alu_res = src_a ^ src_b;
          3'b101: alu_res = funct7[5] ? $unsigned($signed(src_a) >>> shamt) : (src_a >> shamt);
          3'b110: alu_res = src_a | src_b;
          default: alu_res = src_a & src_b;
        endcase
      end
    endcase
  end

  // Operand magnitudes for the M datapaths. funct3[2] splits mul* from div*/rem*;
  // mul treats both as signed since its low half is sign-agnostic anyway.
  always_comb begin
    a_neg    = (funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11)) & src_a[XLEN-1];
    b_neg    = (funct3[2] ? ~funct3[0] : ~funct3[1]) & src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    div_zero = (src_b == '0);
    div_ovf  = ~funct3[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);
  end

  // One shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    mul_prod = neg_q ? -mul_nxt : mul_nxt;
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the difference only if it did not go negative.
  always_comb begin
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_nxt  = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    div_quo  = neg_q  ? -div_nxt[XLEN-1:0]      : div_nxt[XLEN-1:0];
    div_rem  = rneg_q ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    f3_d        = f3_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
        if (accept) begin
          f3_d = funct3;
          if (is_m && MUL_EN) begin
            if (!funct3[2]) begin
              acc_d   = {{XLEN{1'b0}}, b_mag};
              opnd_d  = a_mag;
              neg_d   = a_neg ^ b_neg;
              cnt_d   = CW'(XLEN);
              state_d = S_MUL;
            end else if (div_zero) begin
              result_d    = funct3[1] ? src_a : {XLEN{1'b1}};
              illegal_d   = 1'b0;
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end else if (div_ovf) begin
              result_d    = funct3[1] ? {XLEN{1'b0}} : src_a;
              illegal_d   = 1'b0;
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, a_mag};
              opnd_d  = b_mag;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              cnt_d   = CW'(XLEN);
              state_d = S_DIV;
            end
          end else begin
            result_d    = (is_m || bad_f7) ? {XLEN{1'b0}} : alu_res;
            illegal_d   = is_m || bad_f7;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q - CW'(1);
        // The last step and the sign/half selection share one edge
        if (cnt_q == CW'(1)) begin
          result_d    = (f3_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d    = f3_q[1] ? div_rem : div_quo;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      f3_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      f3_q        <= f3_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7, op;
  logic [31:0] src_a, src_b;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, illegal;

  logic        nm_valid, nm_in_ready, nm_out_valid, nm_out_ready, nm_zero, nm_illegal;
  logic [31:0] nm_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen = 0;

  typedef struct {
    logic [31:0] r;
    logic        ill;
    int          lat;
    int          t;
  } exp_t;

  exp_t scb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(nm_valid), .in_ready(nm_in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .result(nm_result), .zero(nm_zero), .illegal(nm_illegal)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: RISC-V semantics computed with wide arithmetic
  function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] pa, pb, p;
    logic signed [31:0] sa, sbv;
    logic [31:0] q, r;
    e.r = 0; e.ill = 0; e.lat = 1; e.t = 0;
    sa = a; sbv = b;
    case (aop)
      2'b00: e.r = a + b;
      2'b01: e.r = a - b;
      2'b11: e.r = b;
      default: begin
        if (opc == 7'h33 && f7 == 7'h01) begin
          if (f3 < 3'd4) begin
            pa = (f3 == 3'd3) ? {32'b0, a} : {{32{a[31]}}, a};
            pb = (f3 <= 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
            p = pa * pb;
            e.r = (f3 == 3'd0) ? p[31:0] : p[63:32];
            e.lat = 33;
          end else begin
            if (b == 0) begin
              q = 32'hFFFFFFFF; r = a;
            end else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
              q = a; r = 0;
            end else if (!f3[0]) begin
              q = sa / sbv; r = sa % sbv; e.lat = 33;
            end else begin
              q = a / b; r = a % b; e.lat = 33;
            end
            e.r = f3[1] ? r : q;
          end
        end else if (opc[5] && f7 != 7'h00 && f7 != 7'h20 && f7 != 7'h01) begin
          e.ill = 1;
        end else begin
          case (f3)
            3'd0: e.r = (opc[5] && f7[5]) ? a - b : a + b;
            3'd1: e.r = a << b[4:0];
            3'd2: e.r = (sa < sbv) ? 1 : 0;
            3'd3: e.r = (a < b) ? 1 : 0;
            3'd4: e.r = a ^ b;
            3'd5: e.r = f7[5] ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: e.r = a | b;
            default: e.r = a & b;
          endcase
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: check latency on first sight of out_valid, contents on handoff
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        chk("op_pending", scb.size() != 0, 1);
        if (scb.size() != 0) begin
          if (!seen) begin
            chk("latency", cyc - scb[0].t, scb[0].lat);
            seen = 1;
          end
          if (out_ready) begin
            e = scb.pop_front();
            chk("sb_result", result, e.r);
            chk("sb_illegal", illegal, e.ill);
            chk("sb_zero", zero, e.r == 0);
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(ALUOp, funct3, funct7, op, src_a, src_b);
        e.t = cyc;
        scb.push_back(e);
      end
    end
  end

  task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
    ALUOp = aop; funct3 = f3; funct7 = f7; op = opc; src_a = a; src_b = b;
  endtask

  task automatic run_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat, input string nm);
    int n, lo;
    @(posedge clk); #1;
    drive(aop, f3, f7, opc, a, b);
    in_valid = 1;
    @(negedge clk);
    chk({nm, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    n = 1; lo = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (!in_ready) lo++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_result"}, result, exp_r);
    chk({nm, "_zero"}, zero, exp_r == 0);
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_busy_cycles"}, lo, exp_lat - 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; nm_valid = 0; nm_out_ready = 1;
    drive(2'b00, 3'b000, 7'h00, 7'h33, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;

    run_op(2'b10, 3'b000, 7'h20, 7'h33, 5, 7, 32'hFFFFFFFE, 1, "sub");
    run_op(2'b10, 3'b101, 7'h20, 7'h33, 32'h80000000, 4, 32'hF8000000, 1, "sra");
    run_op(2'b10, 3'b001, 7'h01, 7'h33, -3, 7, 32'hFFFFFFFF, 33, "mulh");
    run_op(2'b10, 3'b011, 7'h01, 7'h33, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    run_op(2'b10, 3'b100, 7'h01, 7'h33, -7, 2, 32'hFFFFFFFD, 33, "div");
    run_op(2'b10, 3'b110, 7'h01, 7'h33, -7, 2, 32'hFFFFFFFF, 33, "rem");
    run_op(2'b10, 3'b101, 7'h01, 7'h33, 12345, 0, 32'hFFFFFFFF, 1, "divu_zero");
    run_op(2'b10, 3'b100, 7'h01, 7'h33, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run_op(2'b10, 3'b110, 7'h01, 7'h33, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem_ovf");

    // Back-pressure then back-to-back acceptance
    @(posedge clk); #1;
    out_ready = 0;
    drive(2'b00, 3'b000, 7'h00, 7'h33, 10, 20);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", result, 30);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1;
    drive(2'b10, 3'b100, 7'h00, 7'h33, 32'h0000F0F0, 32'h00000FF0);
    in_valid = 1;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_result", result, 32'h0000FF00);

    // Reset in the middle of a divide
    @(posedge clk); #1;
    drive(2'b10, 3'b100, 7'h01, 7'h33, 1000, 7);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    scb.delete();
    seen = 0;
    @(negedge clk);
    rst = 0;
    run_op(2'b00, 3'b000, 7'h00, 7'h33, 3, 4, 7, 1, "post_rst_add");

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, b;
      int sel;
      @(posedge clk); #1;
      in_valid = $urandom % 2;
      out_ready = ($urandom % 4) != 0;
      for (int k = 0; k < 2; k++) begin
        case ($urandom % 6)
          0: a = 0;
          1: a = 32'hFFFFFFFF;
          2: a = 32'h80000000;
          3: a = $urandom % 16;
          4: a = -($urandom % 16);
          default: a = $urandom;
        endcase
        if (k == 0) src_a = a; else src_b = a;
      end
      sel = $urandom % 8;
      ALUOp = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
      funct3 = $urandom % 8;
      op = ($urandom % 2) ? 7'h33 : 7'h13;
      case ($urandom % 4)
        0: funct7 = 7'h00;
        1: funct7 = 7'h20;
        2: funct7 = 7'h01;
        default: funct7 = $urandom % 128;
      endcase
      b = src_b;
      src_b = b;
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 100 && scb.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_empty", scb.size(), 0);

    // Implementation without the M extension
    @(posedge clk); #1;
    drive(2'b10, 3'b000, 7'h01, 7'h33, 6, 7);
    nm_valid = 1;
    @(posedge clk); #1;
    nm_valid = 0;
    @(negedge clk);
    chk("nm_out_valid", nm_out_valid, 1);
    chk("nm_illegal", nm_illegal, 1);
    chk("nm_result", nm_result, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
